hilo_reg: RTL and testbench

- HI/LO special-register unit for the EXE→MEM→WB pipeline.
- Captures the 64-bit multiply/divide result, or MTHI/MTLO operands, when the producing instruction leaves EXE.
- Carries each write through internal MEM and WB slots that mirror the CPU pipeline, and commits to architectural HI/LO at the end of WB.
- Gives EXE fully forwarded HI/LO values for MFHI/MFLO and for accumulate operations.

---
 rtl/hilo_reg.sv | 186 ++++++++++++++++++
 tb/tb_hilo_reg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg -- HI/LO special-register unit for the EXE -> MEM -> WB pipeline.
//
// A HI/LO write (MULT/DIV result, MTHI, MTLO, optional MADD/MSUB) is captured
// when its instruction leaves EXE. It travels through private MEM and WB slots
// that track the CPU pipeline, and it commits to the architectural HI/LO
// registers at the end of WB. EXE always sees a fully forwarded HI/LO through
// hi_o/lo_o: the MEM slot wins over the WB slot, and the WB slot wins over the
// architectural registers. Each half is forwarded independently.
//
// Optional feature macro: HILO_MADD_EN
//   defined   : ex_acc_op = 01 captures {hi_o,lo_o} + ex_hilo_i and
//               ex_acc_op = 10 captures {hi_o,lo_o} - ex_hilo_i (mod 2^64).
//   undefined : ex_acc_op is ignored and every write is a plain write.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   ex_valid   in   1   EXE instruction is valid and retires to MEM this cycle
//   ex_we_hi   in   1   EXE instruction writes HI
//   ex_we_lo   in   1   EXE instruction writes LO
//   ex_hilo_i  in  64   write data {HI,LO}
//   ex_acc_op  in   2   00 plain, 01 MADD, 10 MSUB, 11 plain
//   stall      in   1   EXE held; no capture this cycle
//   flush      in   1   cancels the MEM slot and the EXE capture
//   hi_o       out 32   forwarded HI for EXE
//   lo_o       out 32   forwarded LO for EXE
//   hi_arch    out 32   committed HI
//   lo_arch    out 32   committed LO
// -----------------------------------------------------------------------------
module hilo_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_we_hi,
  input  logic        ex_we_lo,
  input  logic [63:0] ex_hilo_i,
  input  logic [1:0]  ex_acc_op,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] hi_arch,
  output logic [31:0] lo_arch
);

  // MEM slot
  logic        m_vld_q,   m_vld_d;
  logic        m_we_hi_q, m_we_hi_d;
  logic        m_we_lo_q, m_we_lo_d;
  logic [63:0] m_data_q,  m_data_d;

  // WB slot
  logic        w_vld_q,   w_vld_d;
  logic        w_we_hi_q, w_we_hi_d;
  logic        w_we_lo_q, w_we_lo_d;
  logic [63:0] w_data_q,  w_data_d;

  // Architectural registers
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Forwarded {HI,LO} and the value EXE would place in the MEM slot
  logic [31:0] fwd_hi;
  logic [31:0] fwd_lo;
  logic [63:0] cap_data;
  logic        ex_capture;

  // Per-half forwarding: youngest valid writer of that half wins. Flush is
  // deliberately ignored here; EXE is cancelled in a flush cycle, so a
  // cancelled slot's data is never consumed.
  always_comb begin
    fwd_hi = hi_q;
    fwd_lo = lo_q;
    if (m_vld_q && m_we_hi_q) begin
      fwd_hi = m_data_q[63:32];
    end else if (w_vld_q && w_we_hi_q) begin
      fwd_hi = w_data_q[63:32];
    end else begin
      fwd_hi = hi_q;
    end
    if (m_vld_q && m_we_lo_q) begin
      fwd_lo = m_data_q[31:0];
    end else if (w_vld_q && w_we_lo_q) begin
      fwd_lo = w_data_q[31:0];
    end else begin
      fwd_lo = lo_q;
    end
  end

`ifdef HILO_MADD_EN
  // Accumulate path: the base is the forwarded value, so back-to-back
  // MADD/MSUB chain through the MEM slot without a stall.
  always_comb begin
    cap_data = ex_hilo_i;
    case (ex_acc_op)
      2'b01:   cap_data = {fwd_hi, fwd_lo} + ex_hilo_i;
      2'b10:   cap_data = {fwd_hi, fwd_lo} - ex_hilo_i;
      default: cap_data = ex_hilo_i;
    endcase
  end
`else
  // Plain writes only; the accumulate selector has no effect in this build.
  logic unused_acc_op;
  assign unused_acc_op = ^ex_acc_op;
  assign cap_data      = ex_hilo_i;
`endif

  // An EXE write is captured only when it really advances: flush dominates
  // stall, and an invalid EXE slot never writes.
  assign ex_capture = ex_valid & ~stall & ~flush;

  // Next-state: commit from WB, drain MEM into WB, capture EXE into MEM.
  always_comb begin
    // Commit: each half only when its enable is set.
    hi_d = hi_q;
    lo_d = lo_q;
    if (w_vld_q && w_we_hi_q) begin
      hi_d = w_data_q[63:32];
    end else begin
      hi_d = hi_q;
    end
    if (w_vld_q && w_we_lo_q) begin
      lo_d = w_data_q[31:0];
    end else begin
      lo_d = lo_q;
    end

    // MEM -> WB always advances; a flushed MEM instruction never commits
    // because it is the excepting or a younger instruction.
    w_vld_d   = m_vld_q & ~flush;
    w_we_hi_d = m_we_hi_q;
    w_we_lo_d = m_we_lo_q;
    w_data_d  = m_data_q;

    // EXE -> MEM: capture or insert a bubble.
    m_vld_d   = 1'b0;
    m_we_hi_d = 1'b0;
    m_we_lo_d = 1'b0;
    m_data_d  = 64'h0;
    if (ex_capture) begin
      m_vld_d   = ex_we_hi | ex_we_lo;
      m_we_hi_d = ex_we_hi;
      m_we_lo_d = ex_we_lo;
      m_data_d  = cap_data;
    end else begin
      m_vld_d   = 1'b0;
      m_we_hi_d = 1'b0;
      m_we_lo_d = 1'b0;
      m_data_d  = 64'h0;
    end
  end

  // Pipeline slot and architectural register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld_q   <= 1'b0;
      m_we_hi_q <= 1'b0;
      m_we_lo_q <= 1'b0;
      m_data_q  <= 64'h0;
      w_vld_q   <= 1'b0;
      w_we_hi_q <= 1'b0;
      w_we_lo_q <= 1'b0;
      w_data_q  <= 64'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      m_vld_q   <= m_vld_d;
      m_we_hi_q <= m_we_hi_d;
      m_we_lo_q <= m_we_lo_d;
      m_data_q  <= m_data_d;
      w_vld_q   <= w_vld_d;
      w_we_hi_q <= w_we_hi_d;
      w_we_lo_q <= w_we_lo_d;
      w_data_q  <= w_data_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o    = fwd_hi;
  assign lo_o    = fwd_lo;
  assign hi_arch = hi_q;
  assign lo_arch = lo_q;

endmodule

// File: tb/tb_hilo_reg.sv
// -----------------------------------------------------------------------------
// tb_hilo_reg -- self-checking bench for hilo_reg.
// The reference model keeps the architectural HI/LO plus an in-order list of
// pending writes; the forwarded view is the architectural value with every
// still-pending write applied oldest first. Directed scenarios are followed by
// randomized traffic, all compared against that model after every edge.
// -----------------------------------------------------------------------------
module tb_hilo_reg;

`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_we_hi;
  logic        ex_we_lo;
  logic [63:0] ex_hilo_i;
  logic [1:0]  ex_acc_op;
  logic        stall;
  logic        flush;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] hi_arch;
  logic [31:0] lo_arch;

  int n_checks = 0;
  int n_fails  = 0;

  hilo_reg dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_we_hi  (ex_we_hi),
    .ex_we_lo  (ex_we_lo),
    .ex_hilo_i (ex_hilo_i),
    .ex_acc_op (ex_acc_op),
    .stall     (stall),
    .flush     (flush),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .hi_arch   (hi_arch),
    .lo_arch   (lo_arch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        vld;
    logic        we_hi;
    logic        we_lo;
    logic [63:0] data;
  } wr_t;

  wr_t         pend[$];   // pending writes, oldest first; front = next to commit
  logic [31:0] arch_hi;
  logic [31:0] arch_lo;

  task automatic model_reset();
    wr_t b;
    b = '0;
    arch_hi = 32'h0;
    arch_lo = 32'h0;
    pend.delete();
    pend.push_back(b);
    pend.push_back(b);
  endtask

  task automatic model_fwd(output logic [31:0] fh, output logic [31:0] fl);
    fh = arch_hi;
    fl = arch_lo;
    foreach (pend[i]) begin
      if (pend[i].vld && pend[i].we_hi) fh = pend[i].data[63:32];
      if (pend[i].vld && pend[i].we_lo) fl = pend[i].data[31:0];
    end
  endtask

  task automatic model_edge(input logic v, input logic wh, input logic wl,
                            input logic [63:0] d, input logic [1:0] acc,
                            input logic st, input logic fl);
    logic [31:0] fh;
    logic [31:0] flo;
    wr_t nw;
    wr_t old;
    model_fwd(fh, flo);
    nw = '0;
    if (v && !st && !fl) begin
      nw.vld   = wh | wl;
      nw.we_hi = wh;
      nw.we_lo = wl;
      nw.data  = d;
      if (MADD_EN && acc == 2'b01) nw.data = {fh, flo} + d;
      if (MADD_EN && acc == 2'b10) nw.data = {fh, flo} - d;
    end
    if (fl) begin
      old = pend[1];
      old.vld = 1'b0;
      pend[1] = old;
    end
    old = pend.pop_front();
    if (old.vld && old.we_hi) arch_hi = old.data[63:32];
    if (old.vld && old.we_lo) arch_lo = old.data[31:0];
    pend.push_back(nw);
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] fh;
    logic [31:0] flo;
    model_fwd(fh, flo);
    check_val("hi_o",    {32'h0, hi_o},    {32'h0, fh});
    check_val("lo_o",    {32'h0, lo_o},    {32'h0, flo});
    check_val("hi_arch", {32'h0, hi_arch}, {32'h0, arch_hi});
    check_val("lo_arch", {32'h0, lo_arch}, {32'h0, arch_lo});
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input logic v, input logic wh, input logic wl,
                      input logic [63:0] d, input logic [1:0] acc,
                      input logic st, input logic fl);
    ex_valid  = v;
    ex_we_hi  = wh;
    ex_we_lo  = wl;
    ex_hilo_i = d;
    ex_acc_op = acc;
    stall     = st;
    flush     = fl;
    model_edge(v, wh, wl, d, acc, st, fl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_hi_o",    {32'h0, hi_o},    64'h0);
    check_val("rst_lo_o",    {32'h0, lo_o},    64'h0);
    check_val("rst_hi_arch", {32'h0, hi_arch}, 64'h0);
    check_val("rst_lo_arch", {32'h0, lo_arch}, 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    ex_valid  = 1'b0;
    ex_we_hi  = 1'b0;
    ex_we_lo  = 1'b0;
    ex_hilo_i = 64'h0;
    ex_acc_op = 2'b00;
    stall     = 1'b0;
    flush     = 1'b0;
    model_reset();
    #12;
    check_val("init_hi_o",    {32'h0, hi_o},    64'h0);
    check_val("init_lo_o",    {32'h0, lo_o},    64'h0);
    check_val("init_hi_arch", {32'h0, hi_arch}, 64'h0);
    check_val("init_lo_arch", {32'h0, lo_arch}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-stream with both slots full, then a MULT result.
    step(1'b1, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'h5555_6666_7777_8888, 2'b00, 1'b0, 1'b0);
    reset_pulse();
    step(1'b1, 1'b1, 1'b1, 64'h0000_0001_FFFF_FFFE, 2'b00, 1'b0, 1'b0);
    check_val("mult_fwd", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    idle();
    check_val("mult_arch_early", {hi_arch, lo_arch}, 64'h0);
    idle();
    check_val("mult_arch", {hi_arch, lo_arch}, 64'h0000_0001_FFFF_FFFE);

    // Forwarding chain: MTHI then MTLO.
    step(1'b1, 1'b1, 1'b0, 64'hAAAA_0000_0000_0000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_5555, 2'b00, 1'b0, 1'b0);
    check_val("chain_hi_o", {32'h0, hi_o}, 64'h0000_0000_AAAA_0000);
    check_val("chain_lo_o", {32'h0, lo_o}, 64'h0000_0000_0000_5555);
    idle();
    check_val("chain_hi_arch", {hi_arch, lo_arch}, 64'hAAAA_0000_FFFF_FFFE);
    idle();
    check_val("chain_arch", {hi_arch, lo_arch}, 64'hAAAA_0000_0000_5555);

    // Stall: earlier write drains while EXE is held.
    step(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_1234, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h9999_9999_0000_0000, 2'b00, 1'b1, 1'b0);
    check_val("stall_lo_o", {32'h0, lo_o}, 64'h0000_0000_0000_1234);
    step(1'b1, 1'b1, 1'b0, 64'h9999_9999_0000_0000, 2'b00, 1'b1, 1'b0);
    check_val("stall_lo_arch", {32'h0, lo_arch}, 64'h0000_0000_0000_1234);
    step(1'b1, 1'b1, 1'b0, 64'h9999_9999_0000_0000, 2'b00, 1'b1, 1'b0);
    idle();
    idle();
    check_val("stall_hi_arch", {32'h0, hi_arch}, 64'h0000_0000_AAAA_0000);

    // Flush: WB write commits, MEM write and EXE write are dropped.
    step(1'b1, 1'b1, 1'b0, 64'h0000_BEEF_0000_0000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h0000_DEAD_0000_0000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h0000_F00D_0000_0000, 2'b00, 1'b0, 1'b1);
    check_val("flush_wb_commit", {32'h0, hi_arch}, 64'h0000_0000_0000_BEEF);
    idle();
    idle();
    check_val("flush_cancel", {32'h0, hi_arch}, 64'h0000_0000_0000_BEEF);

    // Flush together with stall: flush dominates.
    step(1'b1, 1'b1, 1'b0, 64'h0000_CAFE_0000_0000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h0000_1111_0000_0000, 2'b00, 1'b1, 1'b1);
    idle();
    idle();
    check_val("flush_stall", {32'h0, hi_arch}, 64'h0000_0000_0000_BEEF);

    // MADD / MSUB (plain writes when the feature is compiled out).
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 2'b01, 1'b0, 1'b0);
    check_val("madd_fwd", {hi_o, lo_o},
              MADD_EN ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001);
    idle();
    idle();
    check_val("madd_arch", {hi_arch, lo_arch},
              MADD_EN ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001);
    step(1'b1, 1'b1, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0002, 2'b10, 1'b0, 1'b0);
    idle();
    idle();
    check_val("msub_arch", {hi_arch, lo_arch},
              MADD_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0000_0000_0000_0002);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0010, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0005, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0007, 2'b01, 1'b0, 1'b0);
    idle();
    idle();
    check_val("madd_chain", {hi_arch, lo_arch},
              MADD_EN ? 64'h0000_0000_0000_001C : 64'h0000_0000_0000_0007);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             {$urandom, $urandom},
             2'($urandom_range(0, 3)),
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
